// File: rtl/hazard_stall_if.sv
// Interlock bundle between the hazard stall unit and the pipeline datapath.
// Data memory handshake: an access completes on the cycle dmem_req_EX_MEM and dmem_ready are both high; req high with ready low stalls the pipe.
interface hazard_stall_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       reg_file_read_address_0_IF_ID;
    logic [4:0]       reg_file_read_address_1_IF_ID;
    logic             uses_rs1_IF_ID;
    logic             uses_rs2_IF_ID;
    logic             reg_file_write_ID_EXE;
    logic [4:0]       reg_file_write_address_ID_EXE;
    logic [1:0]       mux_0_sel_ID_EXE;
    logic             branch_taken_EXE;
    logic             dmem_req_EX_MEM;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       fsm_state;

    modport master (
        output reg_file_read_address_0_IF_ID, reg_file_read_address_1_IF_ID,
               uses_rs1_IF_ID, uses_rs2_IF_ID, reg_file_write_ID_EXE,
               reg_file_write_address_ID_EXE, mux_0_sel_ID_EXE, branch_taken_EXE,
               dmem_req_EX_MEM, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout_err, stall_cycles, flush_count, fsm_state
    );

    modport slave (
        input  reg_file_read_address_0_IF_ID, reg_file_read_address_1_IF_ID,
               uses_rs1_IF_ID, uses_rs2_IF_ID, reg_file_write_ID_EXE,
               reg_file_write_address_ID_EXE, mux_0_sel_ID_EXE, branch_taken_EXE,
               dmem_req_EX_MEM, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout_err, stall_cycles, flush_count, fsm_state
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use bubbles, branch flushes, memory-wait freeze and timeout trap.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           rst_n,
    hazard_stall_if.slave hs
);
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // With the timeout disabled the counter just saturates at all-ones.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT == 0) ? {WAIT_W{1'b1}} : WAIT_W'(MEM_TIMEOUT);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic load_use;
    logic mem_stall;
    logic hold_now;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;

    always_comb begin
        load_use = hs.reg_file_write_ID_EXE && (hs.mux_0_sel_ID_EXE == 2'b01) &&
                   (hs.reg_file_write_address_ID_EXE != 5'd0) &&
                   ((hs.uses_rs1_IF_ID && (hs.reg_file_read_address_0_IF_ID == hs.reg_file_write_address_ID_EXE)) ||
                    (hs.uses_rs2_IF_ID && (hs.reg_file_read_address_1_IF_ID == hs.reg_file_write_address_ID_EXE)));
        mem_stall = hs.dmem_req_EX_MEM && !hs.dmem_ready;
        hold_now  = ((state == ST_RUN) && mem_stall) ||
                    ((state == ST_MEM_WAIT) && !hs.dmem_ready) ||
                    (state == ST_TRAP);
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hold_now) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (hs.branch_taken_EXE) begin
            // The load-use victim is squashed by the flush, so no bubble is needed.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!hs.dmem_ready) begin
                        if (TIMEOUT_EN && (wait_cnt == WAIT_LIMIT)) begin
                            state <= ST_TRAP;
                        end else if (wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign hs.pc_write        = pc_write;
    assign hs.if_id_write     = if_id_write;
    assign hs.if_id_flush     = if_id_flush;
    assign hs.id_ex_flush     = id_ex_flush;
    assign hs.pipe_hold       = pipe_hold;
    assign hs.mem_timeout_err = (state == ST_TRAP);
    assign hs.fsm_state       = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
            if (if_id_flush && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
        end
    end

    assign hs.stall_cycles = stall_q;
    assign hs.flush_count  = flush_q;
`else
    assign hs.stall_cycles = '0;
    assign hs.flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_stall_unit;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout_err}
  localparam logic [5:0] V_RESET  = 6'b001100;
  localparam logic [5:0] V_NORMAL = 6'b110000;
  localparam logic [5:0] V_BUBBLE = 6'b000100;
  localparam logic [5:0] V_BRANCH = 6'b111100;
  localparam logic [5:0] V_HOLD   = 6'b000010;
  localparam logic [5:0] V_TRAP   = 6'b000011;

  logic clk;
  logic rst_n;
  int checks;
  int errors;

  hazard_stall_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hs   (bus.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pipeline mode 0=running, 1=waiting on memory, 2=trapped
  int         m_mode;
  int         m_wait;
  longint     m_stall;
  longint     m_flush;
  logic       m_lu;
  logic       m_busy;
  logic [5:0] m_vec;

  always_comb begin
    m_lu = bus.reg_file_write_ID_EXE && (bus.mux_0_sel_ID_EXE == 2'b01) &&
           (bus.reg_file_write_address_ID_EXE != 5'd0) &&
           ((bus.uses_rs1_IF_ID && (bus.reg_file_read_address_0_IF_ID == bus.reg_file_write_address_ID_EXE)) ||
            (bus.uses_rs2_IF_ID && (bus.reg_file_read_address_1_IF_ID == bus.reg_file_write_address_ID_EXE)));
    m_busy = ((m_mode == 0) && bus.dmem_req_EX_MEM && !bus.dmem_ready) ||
             ((m_mode == 1) && !bus.dmem_ready);
    if (!rst_n) m_vec = V_RESET;
    else if (m_mode == 2) m_vec = V_TRAP;
    else if (m_busy) m_vec = V_HOLD;
    else if (bus.branch_taken_EXE) m_vec = V_BRANCH;
    else if (m_lu) m_vec = V_BUBBLE;
    else m_vec = V_NORMAL;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_wait  <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (!m_vec[5]) m_stall <= m_stall + 1;
      if (m_vec[3]) m_flush <= m_flush + 1;
      if (m_mode == 0 && m_busy) begin
        m_mode <= 1;
        m_wait <= 1;
      end else if (m_mode == 1) begin
        if (!bus.dmem_ready) begin
          if (MEM_TIMEOUT != 0 && m_wait == MEM_TIMEOUT) m_mode <= 2;
          else m_wait <= m_wait + 1;
        end else begin
          m_mode <= 0;
          m_wait <= 0;
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] exp_cnt(input longint v);
    logic [CNT_W-1:0] mask;
    mask = PERF ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
    return CNT_W'(v) & mask;
  endfunction

  function automatic logic [5:0] obs();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush, bus.pipe_hold, bus.mem_timeout_err};
  endfunction

  // driver: apply one cycle of inputs at the falling edge, settle, return for sampling
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic br, input logic req, input logic rdy);
    @(negedge clk);
    bus.reg_file_read_address_0_IF_ID = rs1;
    bus.reg_file_read_address_1_IF_ID = rs2;
    bus.uses_rs1_IF_ID                = u1;
    bus.uses_rs2_IF_ID                = u2;
    bus.reg_file_write_ID_EXE         = we;
    bus.reg_file_write_address_ID_EXE = rd;
    bus.mux_0_sel_ID_EXE              = sel;
    bus.branch_taken_EXE              = br;
    bus.dmem_req_EX_MEM               = req;
    bus.dmem_ready                    = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.reg_file_read_address_0_IF_ID = '0;
    bus.reg_file_read_address_1_IF_ID = '0;
    bus.uses_rs1_IF_ID = 1'b0;
    bus.uses_rs2_IF_ID = 1'b0;
    bus.reg_file_write_ID_EXE = 1'b0;
    bus.reg_file_write_address_ID_EXE = '0;
    bus.mux_0_sel_ID_EXE = '0;
    bus.branch_taken_EXE = 1'b0;
    bus.dmem_req_EX_MEM = 1'b0;
    bus.dmem_ready = 1'b0;
    #2;
    checks++;
    if (obs() !== V_RESET) begin errors++; $display("FAIL reset_outputs got %b want %b", obs(), V_RESET); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0 || bus.fsm_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got stall=%0d flush=%0d st=%0d want 0 0 0", bus.stall_cycles, bus.flush_count, bus.fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL after_reset got %b want %b", obs(), V_NORMAL); end
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_BUBBLE) begin errors++; $display("FAIL load_use_rs1 got %b want %b", obs(), V_BUBBLE); end
    drive(5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL load_use_release got %b want %b", obs(), V_NORMAL); end
    drive(5'd1, 5'd12, 1'b1, 1'b1, 1'b1, 5'd12, 2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_BUBBLE) begin errors++; $display("FAIL load_use_rs2 got %b want %b", obs(), V_BUBBLE); end
  endtask

  task automatic test_no_false_stall();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL no_stall_rd0 got %b want %b", obs(), V_NORMAL); end
    drive(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL no_stall_unused_rs2 got %b want %b", obs(), V_NORMAL); end
    drive(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL no_stall_alu got %b want %b", obs(), V_NORMAL); end
    drive(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL no_stall_pc4 got %b want %b", obs(), V_NORMAL); end
  endtask

  task automatic test_branch_load_use();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== V_BRANCH) begin errors++; $display("FAIL branch_over_load_use got %b want %b", obs(), V_BRANCH); end
    idle();
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_st [3];
    exp_st[0] = 2'd0; exp_st[1] = 2'd1; exp_st[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs() !== V_HOLD || bus.fsm_state !== exp_st[i]) begin
        errors++; $display("FAIL mem_wait_hold%0d got %b st=%0d want %b st=%0d", i, obs(), bus.fsm_state, V_HOLD, exp_st[i]);
      end
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL mem_wait_done got %b want %b", obs(), V_NORMAL); end
    idle();
    checks++;
    if (bus.fsm_state !== 2'd0) begin errors++; $display("FAIL mem_wait_back_to_run got st=%0d want 0", bus.fsm_state); end
    // a load-use that was pending under the freeze takes effect on the ready cycle
    drive(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'b01, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs() !== V_HOLD) begin errors++; $display("FAIL mem_over_load_use got %b want %b", obs(), V_HOLD); end
    drive(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'b01, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs() !== V_BUBBLE) begin errors++; $display("FAIL ready_then_load_use got %b want %b", obs(), V_BUBBLE); end
    idle();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs() !== V_HOLD) begin errors++; $display("FAIL timeout_wait%0d got %b want %b", i, obs(), V_HOLD); end
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs() !== V_TRAP || bus.fsm_state !== 2'd2) begin
      errors++; $display("FAIL timeout_trap got %b st=%0d want %b st=2", obs(), bus.fsm_state, V_TRAP);
    end
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 2'b01, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs() !== V_TRAP) begin errors++; $display("FAIL trap_sticky got %b want %b", obs(), V_TRAP); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== V_RESET || bus.fsm_state !== 2'd0) begin
      errors++; $display("FAIL async_reset_clear got %b st=%0d want %b st=0", obs(), bus.fsm_state, V_RESET);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checks++;
    if (obs() !== V_NORMAL) begin errors++; $display("FAIL after_trap_reset got %b want %b", obs(), V_NORMAL); end
  endtask

  task automatic test_perf();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
    idle();
    drive(5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 2'b01, 1'b0, 1'b0, 1'b0);
    idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle();
    checks++;
    if (bus.stall_cycles !== (PERF ? 16'd2 : 16'd0) || bus.flush_count !== (PERF ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL perf_counts got stall=%0d flush=%0d want %0d %0d", bus.stall_cycles, bus.flush_count, PERF ? 2 : 0, PERF ? 1 : 0);
    end
  endtask

  // scoreboard: expected output vectors from the model, consumed as the DUT is sampled
  logic [5:0] exp_q[$];

  task automatic test_random();
    logic [5:0] exp_v;
    logic       slow;
    for (int i = 0; i < 600; i++) begin
      slow = ((i % 64) >= 44);
      @(negedge clk);
      rst_n = !((m_mode == 2 && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0);
      bus.reg_file_read_address_0_IF_ID = 5'($urandom_range(0, 3));
      bus.reg_file_read_address_1_IF_ID = 5'($urandom_range(0, 3));
      bus.uses_rs1_IF_ID                = 1'($urandom_range(0, 1));
      bus.uses_rs2_IF_ID                = 1'($urandom_range(0, 1));
      bus.reg_file_write_ID_EXE         = 1'($urandom_range(0, 1));
      bus.reg_file_write_address_ID_EXE = 5'($urandom_range(0, 3));
      bus.mux_0_sel_ID_EXE              = 2'($urandom_range(0, 2));
      bus.branch_taken_EXE              = ($urandom_range(0, 5) == 0);
      bus.dmem_req_EX_MEM               = ($urandom_range(0, 2) == 0);
      bus.dmem_ready                    = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      exp_q.push_back(m_vec);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs() !== exp_v || bus.fsm_state !== 2'(m_mode)) begin
        errors++; $display("FAIL random_cycle%0d got %b st=%0d want %b st=%0d", i, obs(), bus.fsm_state, exp_v, m_mode);
      end
      checks++;
      if (bus.stall_cycles !== exp_cnt(m_stall) || bus.flush_count !== exp_cnt(m_flush)) begin
        errors++; $display("FAIL random_perf%0d got stall=%0d flush=%0d want %0d %0d", i, bus.stall_cycles, bus.flush_count, exp_cnt(m_stall), exp_cnt(m_flush));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
